fp_op_issuer: RTL and testbench

Initiator-side driver for the floating-point operation unit's strobe/done interface. It accepts one command (op1, op2, op_sel) over a valid/ready handshake and presents the operands to the FPU. It then pulses `op_strobe` for one cycle, waits for `done`, and returns the captured result and overflow flag over a second valid/ready handshake. It sits between the host/command logic and the FPU wrapper, and is the only block that drives the FPU operand bus.

---
 rtl/fp_issue_pkg.sv | 20 ++
 rtl/fp_issue_timer.sv | 39 +++
 rtl/fp_op_issuer.sv | 123 ++++++++++++
 tb/tb_fp_op_issuer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_issue_pkg.sv
// Shared types for the FPU operation issuer: FSM state encoding, datapath widths, command bundle.
package fp_issue_pkg;

  localparam int FP_WIDTH    = 32;
  localparam int OPSEL_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } fp_issue_state_e;

  typedef struct packed {
    logic [FP_WIDTH-1:0]    op1;
    logic [FP_WIDTH-1:0]    op2;
    logic [OPSEL_WIDTH-1:0] op_sel;
  } fp_cmd_t;

endpackage

// File: rtl/fp_issue_timer.sv
// WAIT-state watchdog: counts cycles without done, flags the terminal count TIMEOUT_CYCLES-1.
// Latency: expired is decoded from the count register, no input-to-output path.
// Backpressure: none; clear has priority over enable, count saturates at the terminal value.
module fp_issue_timer
  import fp_issue_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LAST_CNT)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LAST_CNT);

endmodule

// File: rtl/fp_op_issuer.sv
// Drives the FPU strobe/done interface for one command at a time; optional watchdog via FP_ISSUE_TIMEOUT_EN.
// Latency: accept -> ISSUE (op_strobe) -> WAIT -> HOLD, 3 cycles minimum to res_valid, 4-cycle command period.
// Backpressure: cmd_ready only in IDLE; result held in HOLD until res_ready, no queueing.
module fp_op_issuer
  import fp_issue_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [FP_WIDTH-1:0]    cmd_op1,
  input  logic [FP_WIDTH-1:0]    cmd_op2,
  input  logic [OPSEL_WIDTH-1:0] cmd_op_sel,
  output logic [FP_WIDTH-1:0]    op1,
  output logic [FP_WIDTH-1:0]    op2,
  output logic [OPSEL_WIDTH-1:0] op_sel,
  output logic                   op_strobe,
  input  logic [FP_WIDTH-1:0]    result,
  input  logic                   done,
  input  logic                   overflow,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [FP_WIDTH-1:0]    res_data,
  output logic                   res_overflow,
  output logic                   res_timeout
);

  fp_issue_state_e     state_q, state_d;
  fp_cmd_t             cmd_q, cmd_d;
  logic [FP_WIDTH-1:0] res_data_q, res_data_d;
  logic                res_overflow_q, res_overflow_d;
  logic                res_timeout_q, res_timeout_d;
  logic                tmr_expired;

  if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
    $error("fp_op_issuer: TIMEOUT_CYCLES must lie in 2..65535");
  end

`ifdef FP_ISSUE_TIMEOUT_EN
  fp_issue_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear   (state_q == ISSUE),
    .enable  ((state_q == WAIT) && !done),
    .expired (tmr_expired)
  );
`else
  assign tmr_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (done || tmr_expired) state_d = HOLD;
      HOLD:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
    op_strobe = (state_q == ISSUE);
    res_valid = (state_q == HOLD);
  end

  // done beats a coincident terminal count
  always_comb begin
    cmd_d          = cmd_q;
    res_data_d     = res_data_q;
    res_overflow_d = res_overflow_q;
    res_timeout_d  = res_timeout_q;
    if ((state_q == IDLE) && cmd_valid) begin
      cmd_d = '{op1: cmd_op1, op2: cmd_op2, op_sel: cmd_op_sel};
    end
    if (state_q == WAIT) begin
      if (done) begin
        res_data_d     = result;
        res_overflow_d = overflow;
        res_timeout_d  = 1'b0;
      end else if (tmr_expired) begin
        res_data_d     = '0;
        res_overflow_d = 1'b0;
        res_timeout_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cmd_q          <= '0;
      res_data_q     <= '0;
      res_overflow_q <= 1'b0;
      res_timeout_q  <= 1'b0;
    end else begin
      cmd_q          <= cmd_d;
      res_data_q     <= res_data_d;
      res_overflow_q <= res_overflow_d;
      res_timeout_q  <= res_timeout_d;
    end
  end

  assign op1          = cmd_q.op1;
  assign op2          = cmd_q.op2;
  assign op_sel       = cmd_q.op_sel;
  assign res_data     = res_data_q;
  assign res_overflow = res_overflow_q;
  assign res_timeout  = res_timeout_q;

endmodule

// File: tb/tb_fp_op_issuer.sv
// Directed bench for fp_op_issuer: reset, basic op, backpressure, back-to-back, spurious done, reset mid-WAIT, timeout.
module tb_fp_op_issuer;

  logic        clk;
  logic        n_rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_op1;
  logic [31:0] cmd_op2;
  logic [2:0]  cmd_op_sel;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [2:0]  op_sel;
  logic        op_strobe;
  logic [31:0] result;
  logic        done;
  logic        overflow;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_overflow;
  logic        res_timeout;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int strobe_q[$];

  fp_op_issuer #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op1      (cmd_op1),
    .cmd_op2      (cmd_op2),
    .cmd_op_sel   (cmd_op_sel),
    .op1          (op1),
    .op2          (op2),
    .op_sel       (op_sel),
    .op_strobe    (op_strobe),
    .result       (result),
    .done         (done),
    .overflow     (overflow),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_overflow (res_overflow),
    .res_timeout  (res_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (op_strobe === 1'b1) strobe_q.push_back(cyc);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed time %0t required under 200000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h required %h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b required %b", tag, obs, exp);
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [31:0] b, input logic [2:0] s);
    cmd_valid  = 1'b1;
    cmd_op1    = a;
    cmd_op2    = b;
    cmd_op_sel = s;
  endtask

  logic [2:0] sels [7];
  int         n_before;

  initial begin
    sels = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b011, 3'b111, 3'b000};
    n_rst = 1'b0; cmd_valid = 1'b0; cmd_op1 = '0; cmd_op2 = '0; cmd_op_sel = '0;
    result = '0; done = 1'b0; overflow = 1'b0; res_ready = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk32("rst_op1", op1, 32'h0);
    chk32("rst_op2", op2, 32'h0);
    chk32("rst_op_sel", 32'(op_sel), 32'h0);
    chk1("rst_strobe", op_strobe, 1'b0);
    chk1("rst_res_valid", res_valid, 1'b0);
    chk32("rst_res_data", res_data, 32'h0);
    chk1("rst_res_ovf", res_overflow, 1'b0);
    chk1("rst_res_tmo", res_timeout, 1'b0);
    n_rst = 1'b1;
    tick();
    chk1("rst_cmd_ready", cmd_ready, 1'b1);

    // basic op, done two cycles after the strobe
    n_before = strobe_q.size();
    send_cmd(32'h1, 32'h1, 3'b001);
    tick();
    chk1("basic_strobe", op_strobe, 1'b1);
    chk1("basic_cmd_ready_busy", cmd_ready, 1'b0);
    chk32("basic_op1", op1, 32'h1);
    chk32("basic_op2", op2, 32'h1);
    chk32("basic_op_sel", 32'(op_sel), 32'h1);
    cmd_valid = 1'b0; cmd_op1 = 32'hDEAD_BEEF; cmd_op_sel = 3'b111;
    tick();
    chk1("basic_strobe_one_cycle", op_strobe, 1'b0);
    chk32("basic_op1_wait1", op1, 32'h1);
    tick();
    chk1("basic_no_early_valid", res_valid, 1'b0);
    chk32("basic_op_sel_wait2", 32'(op_sel), 32'h1);
    done = 1'b1; result = 32'h2; overflow = 1'b0;
    tick();
    done = 1'b0; result = '0;
    chk1("basic_res_valid", res_valid, 1'b1);
    chk32("basic_res_data", res_data, 32'h2);
    chk1("basic_res_ovf", res_overflow, 1'b0);
    chk1("basic_res_tmo", res_timeout, 1'b0);
    res_ready = 1'b1;
    tick();
    chk1("basic_res_valid_drop", res_valid, 1'b0);
    chk1("basic_cmd_ready_back", cmd_ready, 1'b1);
    chk32("basic_op1_kept", op1, 32'h1);
    chk32("basic_strobe_count", 32'(strobe_q.size() - n_before), 32'd1);

    // overflow with five cycles of backpressure
    res_ready = 1'b0;
    send_cmd(32'hF, 32'hF, 3'b010);
    tick();
    cmd_valid = 1'b0;
    tick();
    done = 1'b1; result = 32'hFFFF_FFFF; overflow = 1'b1;
    tick();
    done = 1'b0; result = '0; overflow = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk1("bp_res_valid", res_valid, 1'b1);
      chk32("bp_res_data", res_data, 32'hFFFF_FFFF);
      chk1("bp_res_ovf", res_overflow, 1'b1);
      chk1("bp_cmd_ready", cmd_ready, 1'b0);
      tick();
    end
    res_ready = 1'b1;
    tick();
    chk1("bp_release_valid", res_valid, 1'b0);
    chk1("bp_release_ready", cmd_ready, 1'b1);

    // seven back-to-back commands, immediate done, consumer always ready
    strobe_q.delete();
    for (int i = 0; i < 7; i++) begin
      send_cmd(32'(i + 1), 32'(i * 16), sels[i]);
      tick();
      chk1("b2b_strobe", op_strobe, 1'b1);
      chk32("b2b_op_sel", 32'(op_sel), 32'(sels[i]));
      cmd_valid = 1'b0;
      done = 1'b1; result = 32'hC0DE_0000 | 32'(i);
      tick();
      chk1("b2b_wait_no_valid", res_valid, 1'b0);
      tick();
      done = 1'b0;
      chk1("b2b_res_valid", res_valid, 1'b1);
      chk32("b2b_res_data", res_data, 32'hC0DE_0000 | 32'(i));
      tick();
      chk1("b2b_idle_ready", cmd_ready, 1'b1);
    end
    chk32("b2b_strobe_count", 32'(strobe_q.size()), 32'd7);
    for (int j = 0; j + 1 < strobe_q.size(); j++) begin
      chk32("b2b_strobe_period", 32'(strobe_q[j+1] - strobe_q[j]), 32'd4);
    end

    // spurious done during ISSUE and HOLD
    res_ready = 1'b0;
    send_cmd(32'h3, 32'h4, 3'b011);
    tick();
    cmd_valid = 1'b0;
    done = 1'b1; result = 32'hBAD0_0BAD; overflow = 1'b1;
    tick();
    done = 1'b0; result = '0; overflow = 1'b0;
    chk1("spur_issue_no_valid", res_valid, 1'b0);
    tick();
    chk1("spur_wait_no_valid", res_valid, 1'b0);
    done = 1'b1; result = 32'h1234; overflow = 1'b0;
    tick();
    chk1("spur_res_valid", res_valid, 1'b1);
    chk32("spur_res_data", res_data, 32'h1234);
    result = 32'h5555_5555; overflow = 1'b1;
    tick();
    chk32("spur_hold_data", res_data, 32'h1234);
    chk1("spur_hold_ovf", res_overflow, 1'b0);
    res_ready = 1'b1;
    tick();
    chk1("spur_release", res_valid, 1'b0);
    res_ready = 1'b0;
    tick();
    chk1("spur_idle_no_valid", res_valid, 1'b0);
    chk32("spur_idle_data", res_data, 32'h1234);
    done = 1'b0; result = '0; overflow = 1'b0;

`ifdef FP_ISSUE_TIMEOUT_EN
    // no done: abandon after 8 WAIT cycles
    send_cmd(32'h5, 32'h6, 3'b101);
    tick();
    cmd_valid = 1'b0;
    tick();
    chk1("tmo_wait1", res_valid, 1'b0);
    for (int k = 0; k < 7; k++) begin
      tick();
      chk1("tmo_still_waiting", res_valid, 1'b0);
    end
    tick();
    chk1("tmo_res_valid", res_valid, 1'b1);
    chk1("tmo_flag", res_timeout, 1'b1);
    chk32("tmo_res_data", res_data, 32'h0);
    chk1("tmo_res_ovf", res_overflow, 1'b0);
    res_ready = 1'b1;
    tick();
    chk1("tmo_release", cmd_ready, 1'b1);
    res_ready = 1'b0;

    // done on the terminal WAIT cycle wins
    send_cmd(32'h7, 32'h8, 3'b110);
    tick();
    cmd_valid = 1'b0;
    tick();
    repeat (7) tick();
    chk1("tmo_term_no_valid", res_valid, 1'b0);
    done = 1'b1; result = 32'h7777; overflow = 1'b1;
    tick();
    done = 1'b0; result = '0; overflow = 1'b0;
    chk1("tmo_term_valid", res_valid, 1'b1);
    chk1("tmo_term_flag", res_timeout, 1'b0);
    chk32("tmo_term_data", res_data, 32'h7777);
    chk1("tmo_term_ovf", res_overflow, 1'b1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
`else
    // without the watchdog the issuer waits as long as it takes
    send_cmd(32'h5, 32'h6, 3'b101);
    tick();
    cmd_valid = 1'b0;
    repeat (20) tick();
    chk1("nowd_still_waiting", res_valid, 1'b0);
    chk1("nowd_busy", cmd_ready, 1'b0);
    done = 1'b1; result = 32'h7777; overflow = 1'b1;
    tick();
    done = 1'b0; result = '0; overflow = 1'b0;
    chk1("nowd_valid", res_valid, 1'b1);
    chk1("nowd_flag", res_timeout, 1'b0);
    chk32("nowd_data", res_data, 32'h7777);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
`endif

    // reset while in WAIT, late done must be ignored
    send_cmd(32'hAAAA_AAAA, 32'h5555_5555, 3'b111);
    tick();
    cmd_valid = 1'b0;
    tick();
    chk32("mrst_op1_before", op1, 32'hAAAA_AAAA);
    #2 n_rst = 1'b0;
    #1;
    chk32("mrst_op1", op1, 32'h0);
    chk32("mrst_op2", op2, 32'h0);
    chk32("mrst_op_sel", 32'(op_sel), 32'h0);
    chk1("mrst_cmd_ready", cmd_ready, 1'b1);
    chk1("mrst_strobe", op_strobe, 1'b0);
    chk1("mrst_res_valid", res_valid, 1'b0);
    chk32("mrst_res_data", res_data, 32'h0);
    chk1("mrst_res_ovf", res_overflow, 1'b0);
    #2 n_rst = 1'b1;
    done = 1'b1; result = 32'h9999; overflow = 1'b1;
    tick();
    chk1("mrst_late_done_valid", res_valid, 1'b0);
    chk32("mrst_late_done_data", res_data, 32'h0);
    tick();
    chk1("mrst_late_done_valid2", res_valid, 1'b0);
    chk1("mrst_ready_after", cmd_ready, 1'b1);
    done = 1'b0; result = '0; overflow = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
